// File: rtl/vid_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vid_pkg
// Purpose  : Shared defaults and enumerations for the video RAM arbiter slice.
//            c_AW / c_DW      default RAM address / data widths
//            src_t            which requester owns the RAM port this cycle
//            fill_state_t     screen-fill engine states
// Revision : 1.0  initial release
// ============================================================================
package vid_pkg;

    localparam int c_AW = 13;
    localparam int c_DW = 8;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_VID  = 2'd1,
        SRC_CPU  = 2'd2,
        SRC_FILL = 2'd3
    } src_t;

    typedef enum logic [1:0] {
        FILL_IDLE = 2'd0,
        FILL_RUN  = 2'd1,
        FILL_DONE = 2'd2
    } fill_state_t;

endpackage : vid_pkg
`default_nettype wire

// File: rtl/vid_fill_engine.sv
`default_nettype none
// ============================================================================
// Module   : vid_fill_engine
// Purpose  : Writes one byte value over a VRAM region, one byte per granted
//            cycle, through the arbiter's lowest-priority request port.
// Ports    : clk, reset_n                  clock, async active-low reset
//            fill_start/base/len/data      command (sampled only in IDLE)
//            fill_busy, fill_done          status (done = 1-cycle pulse)
//            fill_req / fill_ack           request to / grant from arbiter
//            fill_addr, fill_wdata         write address / data for RAM
// Revision : 1.0  initial release
// ============================================================================
module vid_fill_engine
    import vid_pkg::*;
#(
    parameter int AW = c_AW,
    parameter int DW = c_DW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          fill_start,
    input  logic [AW-1:0] fill_base,
    input  logic [AW-1:0] fill_len,
    input  logic [DW-1:0] fill_data,
    output logic          fill_busy,
    output logic          fill_done,
    output logic          fill_req,
    input  logic          fill_ack,
    output logic [AW-1:0] fill_addr,
    output logic [DW-1:0] fill_wdata
);

    fill_state_t   r_state;
    fill_state_t   w_next_state;
    logic [AW-1:0] r_base;
    logic [AW-1:0] r_len;
    logic [AW-1:0] r_cnt;
    logic [DW-1:0] r_data;
    logic          w_last;

    // The write being granted now is the len-th one.
    assign w_last = ((r_cnt + AW'(1)) == r_len);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= FILL_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            FILL_IDLE: begin
                if (fill_start) begin
                    w_next_state = (fill_len == '0) ? FILL_DONE : FILL_RUN;
                end
            end
            FILL_RUN: begin
                if (fill_ack && w_last) begin
                    w_next_state = FILL_DONE;
                end
            end
            FILL_DONE: w_next_state = FILL_IDLE;
            default:   w_next_state = FILL_IDLE;
        endcase
    end

    always_comb begin
        fill_req  = 1'b0;
        fill_busy = 1'b0;
        fill_done = 1'b0;
        case (r_state)
            FILL_RUN: begin
                fill_req  = 1'b1;
                fill_busy = 1'b1;
            end
            FILL_DONE: begin
                fill_busy = 1'b1;
                fill_done = 1'b1;
            end
            default: ;
        endcase
    end

    // Command registers load only from IDLE, so a start pulse mid-fill
    // cannot disturb the region being written.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_base <= '0;
            r_len  <= '0;
            r_data <= '0;
            r_cnt  <= '0;
        end else if (r_state == FILL_IDLE && fill_start) begin
            r_base <= fill_base;
            r_len  <= fill_len;
            r_data <= fill_data;
            r_cnt  <= '0;
        end else if (fill_req && fill_ack) begin
            r_cnt  <= r_cnt + AW'(1);
        end
    end

    // Natural AW-bit overflow gives the modulo-2**AW wrap.
    assign fill_addr  = r_base + r_cnt;
    assign fill_wdata = r_data;

endmodule : vid_fill_engine
`default_nettype wire

// File: rtl/vid_ram_arb.sv
`default_nettype none
// ============================================================================
// Module   : vid_ram_arb
// Purpose  : Shares one VRAM port between display fetch, CPU and the fill
//            engine. Video first (burst-limited while the CPU waits), then
//            CPU, then fill. Read data returns the cycle after the grant.
// Ports    : clk, reset_n                     clock, async active-low reset
//            vid_req/addr, vid_ack/valid/dout video read channel
//            cpu_req/we/addr/din, cpu_ack/valid/dout  CPU channel
//            fill_start/base/len/data, fill_busy/done  fill command/status
//            ram_we/addr/din, ram_dout        RAM port (1-cycle read latency)
// Revision : 1.0  initial release
// ============================================================================
module vid_ram_arb
    import vid_pkg::*;
#(
    parameter int AW            = c_AW,
    parameter int DW            = c_DW,
    parameter int VID_MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_ack,
    output logic          vid_valid,
    output logic [DW-1:0] vid_dout,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_din,
    output logic          cpu_ack,
    output logic          cpu_valid,
    output logic [DW-1:0] cpu_dout,
    input  logic          fill_start,
    input  logic [AW-1:0] fill_base,
    input  logic [AW-1:0] fill_len,
    input  logic [DW-1:0] fill_data,
    output logic          fill_busy,
    output logic          fill_done,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    localparam int c_BW = $clog2(VID_MAX_BURST + 1);

    src_t          w_src;
    src_t          r_tag;
    logic [c_BW-1:0] r_burst;
    logic          w_burst_full;
    logic          w_fill_req;
    logic          w_fill_ack;
    logic [AW-1:0] w_fill_addr;
    logic [DW-1:0] w_fill_wdata;
    logic [AW-1:0] r_last_addr;
    logic [DW-1:0] r_last_din;

    vid_fill_engine #(
        .AW (AW),
        .DW (DW)
    ) u_fill (
        .clk        (clk),
        .reset_n    (reset_n),
        .fill_start (fill_start),
        .fill_base  (fill_base),
        .fill_len   (fill_len),
        .fill_data  (fill_data),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done),
        .fill_req   (w_fill_req),
        .fill_ack   (w_fill_ack),
        .fill_addr  (w_fill_addr),
        .fill_wdata (w_fill_wdata)
    );

    assign w_burst_full = (r_burst == c_BW'(VID_MAX_BURST));

    // Reset gates the grant so every ack and the RAM write drop the moment
    // reset_n falls, not at the next edge.
    always_comb begin
        w_src = SRC_NONE;
        if (!reset_n) begin
            w_src = SRC_NONE;
        end else if (cpu_req && w_burst_full) begin
            w_src = SRC_CPU;
        end else if (vid_req) begin
            w_src = SRC_VID;
        end else if (cpu_req) begin
            w_src = SRC_CPU;
        end else if (w_fill_req) begin
            w_src = SRC_FILL;
        end
    end

    assign vid_ack    = (w_src == SRC_VID);
    assign cpu_ack    = (w_src == SRC_CPU);
    assign w_fill_ack = (w_src == SRC_FILL);

    // Idle cycles replay the last address/data so the RAM pins stay quiet.
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = r_last_addr;
        ram_din  = r_last_din;
        case (w_src)
            SRC_VID: begin
                ram_addr = vid_addr;
            end
            SRC_CPU: begin
                ram_we   = cpu_we;
                ram_addr = cpu_addr;
                ram_din  = cpu_din;
            end
            SRC_FILL: begin
                ram_we   = 1'b1;
                ram_addr = w_fill_addr;
                ram_din  = w_fill_wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_addr <= '0;
            r_last_din  <= '0;
            r_tag       <= SRC_NONE;
            r_burst     <= '0;
        end else begin
            r_last_addr <= ram_addr;
            r_last_din  <= ram_din;

            // Tag tells next cycle's RAM data whom it belongs to; CPU writes
            // return nothing.
            if (w_src == SRC_VID) begin
                r_tag <= SRC_VID;
            end else if (w_src == SRC_CPU && !cpu_we) begin
                r_tag <= SRC_CPU;
            end else begin
                r_tag <= SRC_NONE;
            end

            // Counts video grants only while the CPU is waiting.
            if (!cpu_req || w_src == SRC_CPU) begin
                r_burst <= '0;
            end else if (w_src == SRC_VID && !w_burst_full) begin
                r_burst <= r_burst + c_BW'(1);
            end
        end
    end

    assign vid_valid = (r_tag == SRC_VID);
    assign cpu_valid = (r_tag == SRC_CPU);
    assign vid_dout  = vid_valid ? ram_dout : '0;
    assign cpu_dout  = cpu_valid ? ram_dout : '0;

endmodule : vid_ram_arb
`default_nettype wire

// File: tb/tb_vid_ram_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_vid_ram_arb
// Purpose  : Self-checking bench for vid_ram_arb with a 1-cycle registered
//            8 KB RAM model.
// Revision : 1.0  initial release
// ============================================================================
module tb_vid_ram_arb;

    localparam int AW = 13;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          vid_req, vid_ack, vid_valid;
    logic [AW-1:0] vid_addr;
    logic [DW-1:0] vid_dout;
    logic          cpu_req, cpu_we, cpu_ack, cpu_valid;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_din, cpu_dout;
    logic          fill_start, fill_busy, fill_done;
    logic [AW-1:0] fill_base, fill_len;
    logic [DW-1:0] fill_data;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    int n_chk = 0;
    int n_err = 0;

    vid_ram_arb #(.AW(AW), .DW(DW), .VID_MAX_BURST(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
        .vid_valid(vid_valid), .vid_dout(vid_dout),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_ack(cpu_ack), .cpu_valid(cpu_valid), .cpu_dout(cpu_dout),
        .fill_start(fill_start), .fill_base(fill_base), .fill_len(fill_len),
        .fill_data(fill_data), .fill_busy(fill_busy), .fill_done(fill_done),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input logic [12:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    // RAM model: preloaded with pat() while in reset, 1-cycle read latency.
    logic [DW-1:0] mem [0:8191];
    always @(posedge clk) begin
        if (!reset_n) begin
            for (int a = 0; a < 8192; a++) mem[a] <= pat(13'(a));
            ram_dout <= '0;
        end else begin
            if (ram_we) mem[ram_addr] <= ram_din;
            ram_dout <= mem[ram_addr];
        end
    end

    // Monitor: records non-CPU writes (fill writes) and grant conflicts.
    int            fill_wr_cnt  = 0;
    int            overlap_errs = 0;
    logic [AW-1:0] fw_addr [0:4095];
    logic [DW-1:0] fw_data [0:4095];
    always @(negedge clk) begin
        if (vid_ack && cpu_ack) overlap_errs++;
        if (ram_we && vid_ack) overlap_errs++;
        if (ram_we && !cpu_ack) begin
            if (vid_req || cpu_req) overlap_errs++;
            if (fill_wr_cnt < 4096) begin
                fw_addr[fill_wr_cnt] = ram_addr;
                fw_data[fill_wr_cnt] = ram_din;
            end
            fill_wr_cnt++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic vid, cpu, vack, cack, vval, cval;
    } vec_t;
    vec_t tbl [19];

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int            w0, cyc, bad;
        logic [AW-1:0] last_addr, prev_addr, exp_addr;

        // vid, cpu -> vid_ack, cpu_ack, vid_valid, cpu_valid (burst limit 4)
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[15] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[16] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[17] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        reset_n = 1'b0;
        vid_req = 1'b1; vid_addr = 13'h0AAA;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0BBB; cpu_din = 8'hC3;
        fill_start = 1'b0; fill_base = '0; fill_len = '0; fill_data = '0;
        repeat (3) tick;

        // ---------------- reset state (requests held high) ----------------
        chk("rst_vid_ack", vid_ack, 0);
        chk("rst_cpu_ack", cpu_ack, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_din", ram_din, 0);
        chk("rst_valids", {vid_valid, cpu_valid}, 0);
        chk("rst_fill", {fill_busy, fill_done}, 0);
        vid_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
        reset_n = 1'b1;
        tick;

        // ---------------- CPU write then read back ----------------
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0100; cpu_din = 8'h55;
        #1;
        chk("wr_cpu_ack", cpu_ack, 1);
        chk("wr_ram_we", ram_we, 1);
        chk("wr_ram_addr", ram_addr, 13'h0100);
        chk("wr_ram_din", ram_din, 8'h55);
        tick;
        cpu_we = 1'b0;
        #1;
        chk("rd_cpu_ack", cpu_ack, 1);
        chk("rd_ram_we", ram_we, 0);
        chk("no_valid_after_wr", cpu_valid, 0);
        tick;
        cpu_req = 1'b0;
        #1;
        chk("rd_cpu_valid", cpu_valid, 1);
        chk("rd_cpu_dout", cpu_dout, 8'h55);
        tick;
        chk("rd_valid_drop", cpu_valid, 0);
        tick;

        // ---------------- arbitration table ----------------
        last_addr = 13'h0100;
        prev_addr = '0;
        for (int i = 0; i < 19; i++) begin
            vid_req  = tbl[i].vid;
            cpu_req  = tbl[i].cpu;
            vid_addr = 13'h0A00 + 13'(i);
            cpu_addr = 13'h0B00;
            cpu_we   = 1'b0;
            #1;
            chk($sformatf("tbl%0d_vid_ack", i), vid_ack, tbl[i].vack);
            chk($sformatf("tbl%0d_cpu_ack", i), cpu_ack, tbl[i].cack);
            chk($sformatf("tbl%0d_vid_valid", i), vid_valid, tbl[i].vval);
            chk($sformatf("tbl%0d_cpu_valid", i), cpu_valid, tbl[i].cval);
            exp_addr = tbl[i].vack ? vid_addr : (tbl[i].cack ? 13'h0B00 : last_addr);
            chk($sformatf("tbl%0d_ram_addr", i), ram_addr, exp_addr);
            chk($sformatf("tbl%0d_ram_we", i), ram_we, 0);
            if (tbl[i].vval) chk($sformatf("tbl%0d_vid_dout", i), vid_dout, pat(prev_addr));
            if (tbl[i].cval) chk($sformatf("tbl%0d_cpu_dout", i), cpu_dout, pat(prev_addr));
            prev_addr = exp_addr;
            last_addr = exp_addr;
            tick;
        end
        vid_req = 1'b0; cpu_req = 1'b0;
        tick;

        // ---------------- 2 KB fill, no other traffic ----------------
        w0 = fill_wr_cnt;
        fill_base = 13'h0000; fill_len = 13'h0800; fill_data = 8'h20; fill_start = 1'b1;
        tick;
        fill_start = 1'b0;
        cyc = 1;
        while (!fill_done && cyc < 3000) begin
            tick;
            cyc++;
        end
        chk("fill2k_done_cycle", 32'(cyc), 2049);
        chk("fill2k_busy_at_done", fill_busy, 1);
        chk("fill2k_writes", 32'(fill_wr_cnt - w0), 2048);
        tick;
        chk("fill2k_done_pulse", {fill_busy, fill_done}, 0);
        bad = 0;
        for (int a = 0; a < 2048; a++) if (mem[a] !== 8'h20) bad++;
        chk("fill2k_readback_bad", 32'(bad), 0);
        chk("fill2k_byte_0800", mem[13'h0800], pat(13'h0800));
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h07FF;
        tick;
        cpu_req = 1'b0;
        #1;
        chk("fill2k_cpu_readback", {cpu_valid, cpu_dout}, {1'b1, 8'h20});
        tick;

        // ---------------- wrapping fill under random traffic ----------------
        w0 = fill_wr_cnt;
        fill_base = 13'h1FFE; fill_len = 13'd3; fill_data = 8'h3C; fill_start = 1'b1;
        tick;
        fill_start = 1'b0;
        cyc = 0;
        while (!fill_done && cyc < 300) begin
            vid_req  = 1'($urandom_range(0, 1));
            cpu_req  = 1'($urandom_range(0, 1));
            vid_addr = 13'($urandom);
            cpu_addr = 13'($urandom);
            cpu_we   = 1'b0;
            #1;
            if (fill_done) break;
            tick;
            cyc++;
        end
        vid_req = 1'b0; cpu_req = 1'b0;
        chk("wrap_done_seen", fill_done, 1);
        chk("wrap_writes", 32'(fill_wr_cnt - w0), 3);
        chk("wrap_addr0", fw_addr[w0], 13'h1FFE);
        chk("wrap_addr1", fw_addr[w0 + 1], 13'h1FFF);
        chk("wrap_addr2", fw_addr[w0 + 2], 13'h0000);
        chk("wrap_data", {fw_data[w0], fw_data[w0 + 1], fw_data[w0 + 2]}, 24'h3C3C3C);
        tick;
        tick;

        // ---------------- zero-length fill ----------------
        w0 = fill_wr_cnt;
        fill_base = 13'h0123; fill_len = 13'd0; fill_data = 8'hFF; fill_start = 1'b1;
        #1;
        chk("len0_busy_before", fill_busy, 0);
        tick;
        fill_start = 1'b0;
        chk("len0_busy_done", {fill_busy, fill_done}, 2'b11);
        tick;
        chk("len0_idle", {fill_busy, fill_done}, 2'b00);
        chk("len0_writes", 32'(fill_wr_cnt - w0), 0);

        // ---------------- fill_start ignored while running ----------------
        w0 = fill_wr_cnt;
        vid_req = 1'b1; vid_addr = 13'h0050;
        fill_base = 13'h0300; fill_len = 13'd5; fill_data = 8'h11; fill_start = 1'b1;
        tick;
        fill_start = 1'b0;
        chk("ign_busy_run", fill_busy, 1);
        tick;
        fill_base = 13'h0400; fill_len = 13'd2; fill_data = 8'hEE; fill_start = 1'b1;
        tick;
        fill_start = 1'b0;
        vid_req = 1'b0;
        cyc = 0;
        while (!fill_done && cyc < 50) begin
            tick;
            cyc++;
        end
        chk("ign_done_seen", fill_done, 1);
        chk("ign_writes", 32'(fill_wr_cnt - w0), 5);
        chk("ign_first_addr", fw_addr[w0], 13'h0300);
        chk("ign_last", {fw_addr[w0 + 4], fw_data[w0 + 4]}, {13'h0304, 8'h11});
        tick;
        tick;

        // ---------------- reset in the middle of a fill ----------------
        w0 = fill_wr_cnt;
        fill_base = 13'h1000; fill_len = 13'd100; fill_data = 8'h99; fill_start = 1'b1;
        tick;
        fill_start = 1'b0;
        cyc = 0;
        while ((fill_wr_cnt - w0) < 10 && cyc < 100) begin
            tick;
            cyc++;
        end
        chk("mid_writes_before", 32'(fill_wr_cnt - w0), 10);
        chk("mid_running", {fill_busy, ram_we}, 2'b11);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_we", ram_we, 0);
        chk("mid_rst_addr", ram_addr, 0);
        chk("mid_rst_din", ram_din, 0);
        chk("mid_rst_busy", fill_busy, 0);
        repeat (2) tick;
        reset_n = 1'b1;
        repeat (20) tick;
        chk("mid_no_more_writes", 32'(fill_wr_cnt - w0), 10);
        chk("mid_idle_after", {fill_busy, fill_done}, 0);

        chk("no_grant_overlap", 32'(overlap_errs), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule : tb_vid_ram_arb
`default_nettype wire
